// File: rtl/align_sticky_shifter_pkg.sv
// Shared FPU datapath constants and types for the alignment shifter slice.
// Default widths target single precision: 24-bit significand plus guard and round.
package fpu_pkg;

  localparam int SIG_W   = 24;
  localparam int GRS_W   = 2;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [SIG_W+GRS_W-1:0] sig;
    logic                   sticky;
  } aligned_t;

endpackage

// File: rtl/align_sticky_shifter_if.sv
// Valid/ready bundle carrying one alignment request in and one aligned result out.
// The shifter is the slave; the exponent-compare stage and the adder together form the master.
interface align_sticky_shifter_if
  import fpu_pkg::*;
#(
  parameter int WIDTH = SIG_W,
  parameter int SHW   = SHAMT_W
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_sig;
  logic [SHW-1:0]         in_shamt;
  logic                   in_sticky;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH+GRS_W-1:0] out_sig;
  logic                   out_sticky;

  modport master (
    output in_valid, in_sig, in_shamt, in_sticky, out_ready,
    input  in_ready, out_valid, out_sig, out_sticky
  );

  modport slave (
    input  in_valid, in_sig, in_shamt, in_sticky, out_ready,
    output in_ready, out_valid, out_sig, out_sticky
  );

endinterface

// File: rtl/align_sticky_shifter_ortree.sv
// OR-reduction of a bit vector; the sticky-bit collapse used by the alignment shifter.
module ortree #(
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any_set
);

  assign any_set = |vec;

endmodule

// File: rtl/align_sticky_shifter.sv
// Two-stage exponent-alignment right shifter: S1 shifts and captures the lost bits,
// S2 collapses the lost bits into sticky through ortree. Valid/ready on both sides.
module align_sticky_shifter
  import fpu_pkg::*;
#(
  parameter int WIDTH = SIG_W,
  parameter int SHW   = SHAMT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  align_sticky_shifter_if.slave bus
);

  localparam int EW = WIDTH + GRS_W;

  logic [EW-1:0] ext;
  logic [EW-1:0] shifted;
  logic [EW-1:0] lost;

  logic          s1_valid;
  logic [EW-1:0] s1_sig;
  logic [EW-1:0] s1_lost;
  logic          s1_sticky;

  logic          out_valid_q;
  logic [EW-1:0] out_sig_q;
  logic          out_sticky_q;

  logic          lost_any;
  logic          s1_adv;
  logic          s2_adv;

  assign ext = {bus.in_sig, {GRS_W{1'b0}}};

  always_comb begin
    // NOTE: both outputs get a default before the branch, so no path leaves them unassigned (no latch).
    shifted = '0;
    lost    = ext;
    if (int'(bus.in_shamt) < EW) begin
      shifted = ext >> bus.in_shamt;
      lost    = ext & ~({EW{1'b1}} << bus.in_shamt);
    end
  end

  // S2 may advance when empty or being drained; S1 when empty or S2 advances.
  assign s2_adv = !out_valid_q || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready   = rst || s1_adv;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sig    = out_sig_q;
  assign bus.out_sticky = out_sticky_q;

  ortree #(
    .WIDTH (EW)
  ) u_ortree (
    .vec     (s1_lost),
    .any_set (lost_any)
  );

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sig       <= '0;
      s1_lost      <= '0;
      s1_sticky    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sig_q    <= '0;
      out_sticky_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          out_sig_q    <= s1_sig;
          out_sticky_q <= lost_any | s1_sticky;
        end
      end
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sig    <= shifted;
          s1_lost   <= lost;
          s1_sticky <= bus.in_sticky;
        end
      end
    end
  end

endmodule
